// File: rtl/apb_rr_master_pkg.sv
// apb_ctrl_pkg: definitions shared by the APB round-robin master and its arbiter.
//   apb_state_t  - controller state (IDLE / SETUP / ACCESS)
//   PHASE_*      - {PSELx, PENABLE} encodings for each bus phase
//   next_rr()    - round-robin pick: first set request at or after ptr+1 (mod n)
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    // {PSELx, PENABLE}
    localparam logic [1:0] PHASE_IDLE   = 2'b00;
    localparam logic [1:0] PHASE_SETUP  = 2'b10;
    localparam logic [1:0] PHASE_ACCESS = 2'b11;

    localparam int MAX_REQ = 8;

    // Walks the candidates from farthest to nearest so that the nearest one
    // after the pointer is the last assignment and therefore wins. Returns the
    // pointer unchanged when nothing is requesting.
    function automatic int next_rr(input int ptr, input logic [MAX_REQ-1:0] req, input int n);
        int pick;
        int cand;
        pick = ptr;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                cand = (ptr + k) % n;
                if (req[cand[2:0]]) begin
                    pick = cand;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/apb_rr_master_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req   in  NREQ          request vector
//   ptr   in  $clog2(NREQ)  index of the most recently served requester
//   grant out NREQ          onehot grant (all zero when nothing requests)
//   idx   out $clog2(NREQ)  index of the granted requester
//   any   out 1             at least one request present
module rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IDX_W = $clog2(NREQ);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext = '0;
        req_ext[NREQ-1:0] = req;
        idx = IDX_W'(next_rr(int'(ptr), req_ext, NREQ));
        any = |req;
        grant = '0;
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: shares one APB bus between NREQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing, wait states and a wait-state timeout.
//   PCLK, PRESETn                 clock, synchronous active-low reset
//   req_valid/ready/write/addr/wdata  per-requester request channel (packed)
//   rsp_valid/rdata/err           one-cycle completion to the owning requester
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA, PRDATA/PREADY/PSLVERR  APB master side
module apb_rr_master
    import apb_ctrl_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     PSELx,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int IDX_W = $clog2(NREQ);
    // A zero-width counter is not legal, so a disabled timeout keeps one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT);

    apb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W:0]     wait_next;

    logic [NREQ-1:0]    arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign wait_next = {1'b0, wait_cnt} + (CNT_W + 1)'(1);

    // Only IDLE offers a grant; nothing is accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (PRESETn && state == IDLE) begin
            req_ready = arb_grant;
        end
    end

    // Payload of the granted requester.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // rr_ptr doubles as the owner of the in-flight transfer, since it is set
    // to the granted index on acceptance and not touched until the next one.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(NREQ - 1);
            wait_cnt  <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        PWRITE            <= sel_write;
                        PADDR             <= sel_addr;
                        PWDATA            <= sel_wdata;
                        rr_ptr            <= arb_idx;
                        wait_cnt          <= '0;
                        {PSELx, PENABLE}  <= PHASE_SETUP;
                        state             <= SETUP;
                    end
                end
                SETUP: begin
                    {PSELx, PENABLE} <= PHASE_ACCESS;
                    state            <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        {PSELx, PENABLE}  <= PHASE_IDLE;
                        state             <= IDLE;
                        rsp_valid[rr_ptr] <= 1'b1;
                        rsp_err           <= PSLVERR;
                        rsp_rdata         <= PWRITE ? '0 : PRDATA;
                    end else if (TIMEOUT > 0 && wait_next == TIMEOUT_VAL) begin
                        {PSELx, PENABLE}  <= PHASE_IDLE;
                        state             <= IDLE;
                        rsp_valid[rr_ptr] <= 1'b1;
                        rsp_err           <= 1'b1;
                    end else begin
                        wait_cnt <= wait_next[CNT_W-1:0];
                    end
                end
                default: begin
                    {PSELx, PENABLE} <= PHASE_IDLE;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed and randomized transfers against apb_rr_master.
// The bench plays the APB slave, keeps a high-level model of which requester
// should be granted next, and checks every bus phase and every response.
module tb_apb_rr_master;

    localparam int NREQ    = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                     PCLK = 1'b0;
    logic                     PRESETn = 1'b0;
    logic [NREQ-1:0]          req_valid = '0;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          req_write = '0;
    logic [NREQ*ADDR_W-1:0]   req_addr = '0;
    logic [NREQ*DATA_W-1:0]   req_wdata = '0;
    logic [NREQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic                     PSELx;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [ADDR_W-1:0]        PADDR;
    logic [DATA_W-1:0]        PWDATA;
    logic [DATA_W-1:0]        PRDATA = '0;
    logic                     PREADY = 1'b0;
    logic                     PSLVERR = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference state: what each requester is currently asking for, and who
    // was served last.
    logic              modelWrite [NREQ];
    logic [ADDR_W-1:0] modelAddr  [NREQ];
    logic [DATA_W-1:0] modelWdata [NREQ];
    int                modelPtr = NREQ - 1;

    apb_rr_master #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        modelWrite[r] = wr;
        modelAddr[r]  = a;
        modelWdata[r] = d;
        req_write[r]  = wr;
        req_addr[r*ADDR_W +: ADDR_W]  = a;
        req_wdata[r*DATA_W +: DATA_W] = d;
    endtask

    // Lowest pending index above the last-served one, else lowest pending overall.
    function automatic int modelGrant();
        int best;
        best = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && i > modelPtr && best < 0) best = i;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && best < 0) best = i;
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] oneHot(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0 && g < NREQ) v[g] = 1'b1;
        return v;
    endfunction

    // Starts at a negedge with the DUT in IDLE and req_valid already set; ends
    // at the negedge of the response cycle, which is also the next IDLE cycle.
    task automatic runTransfer(input int waits, input logic slverr, input logic [DATA_W-1:0] rdval, input logic keepValid);
        int                g;
        logic              expWrite;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expWdata;
        logic              aborted;
        #1;
        g = modelGrant();
        checkOutput("idle_ready", req_ready, oneHot(g));
        checkOutput("idle_phase", {PSELx, PENABLE}, 2'b00);
        expWrite = modelWrite[g];
        expAddr  = modelAddr[g];
        expWdata = modelWdata[g];
        @(posedge PCLK); @(negedge PCLK);
        modelPtr = g;
        if (!keepValid) req_valid[g] = 1'b0;
        checkOutput("setup_phase", {PSELx, PENABLE}, 2'b10);
        checkOutput("setup_addr", PADDR, expAddr);
        checkOutput("setup_write", PWRITE, expWrite);
        checkOutput("setup_wdata", PWDATA, expWdata);
        checkOutput("setup_ready", req_ready, '0);
        PRDATA  = rdval;
        PSLVERR = slverr;
        @(posedge PCLK); @(negedge PCLK);
        aborted = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            checkOutput("access_phase", {PSELx, PENABLE}, 2'b11);
            checkOutput("access_addr", PADDR, expAddr);
            checkOutput("access_wdata", PWDATA, expWdata);
            checkOutput("access_rsp", rsp_valid, '0);
            checkOutput("access_ready", req_ready, '0);
            PREADY = (k == waits);
            if (TIMEOUT > 0 && k < waits && k + 1 == TIMEOUT) aborted = 1'b1;
            @(posedge PCLK); @(negedge PCLK);
            if (aborted) break;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        checkOutput("rsp_valid", rsp_valid, oneHot(g));
        checkOutput("rsp_err", rsp_err, aborted | slverr);
        checkOutput("rsp_rdata", rsp_rdata, (aborted || expWrite) ? '0 : rdval);
        checkOutput("post_phase", {PSELx, PENABLE}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b0, '0, '0);

        // Reset state
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        checkOutput("reset_phase", {PSELx, PENABLE}, 2'b00);
        checkOutput("reset_pwrite", PWRITE, 1'b0);
        checkOutput("reset_paddr", PADDR, '0);
        checkOutput("reset_pwdata", PWDATA, '0);
        checkOutput("reset_rsp_valid", rsp_valid, '0);
        checkOutput("reset_rsp_rdata", rsp_rdata, '0);
        checkOutput("reset_rsp_err", rsp_err, 1'b0);
        checkOutput("reset_ready", req_ready, '0);
        PRESETn = 1'b1;
        modelPtr = NREQ - 1;
        @(posedge PCLK); @(negedge PCLK);

        $display("[TB] single read, zero wait states");
        applyStimulus(0, 1'b0, 32'h04, 32'h0);
        req_valid[0] = 1'b1;
        runTransfer(0, 1'b0, 32'hA5, 1'b0);

        $display("[TB] write with three wait states");
        applyStimulus(1, 1'b1, 32'h00, 32'h55);
        req_valid[1] = 1'b1;
        runTransfer(3, 1'b0, 32'hCAFE, 1'b0);

        $display("[TB] two requesters held valid for four transfers");
        applyStimulus(0, 1'b0, 32'h10, 32'h11);
        applyStimulus(1, 1'b1, 32'h14, 32'h22);
        req_valid = '1;
        for (int n = 0; n < 4; n++) runTransfer(0, 1'b0, 32'h100 + n, 1'b1);
        req_valid = '0;

        $display("[TB] PREADY stuck low, timeout abort");
        applyStimulus(0, 1'b0, 32'h0C, 32'h0);
        req_valid[0] = 1'b1;
        runTransfer(TIMEOUT + 4, 1'b0, 32'hDEAD, 1'b0);

        $display("[TB] slave error on read, then a normal transfer");
        applyStimulus(1, 1'b0, 32'h08, 32'h0);
        req_valid[1] = 1'b1;
        runTransfer(0, 1'b1, 32'h77, 1'b0);
        applyStimulus(0, 1'b0, 32'h04, 32'h0);
        req_valid[0] = 1'b1;
        runTransfer(1, 1'b0, 32'h3C, 1'b0);

        $display("[TB] reset during ACCESS");
        applyStimulus(0, 1'b0, 32'h20, 32'h0);
        req_valid[0] = 1'b1;
        #1;
        checkOutput("rst_pre_ready", req_ready, oneHot(modelGrant()));
        @(posedge PCLK); @(negedge PCLK);
        req_valid[0] = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        checkOutput("rst_pre_phase", {PSELx, PENABLE}, 2'b11);
        PREADY  = 1'b0;
        PRESETn = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        checkOutput("rst_phase", {PSELx, PENABLE}, 2'b00);
        checkOutput("rst_rsp_valid", rsp_valid, '0);
        checkOutput("rst_paddr", PADDR, '0);
        PRESETn  = 1'b1;
        modelPtr = NREQ - 1;
        applyStimulus(1, 1'b1, 32'h30, 32'hBEEF);
        applyStimulus(0, 1'b0, 32'h34, 32'h0);
        req_valid = '1;
        runTransfer(0, 1'b0, 32'h5A, 1'b0);
        runTransfer(0, 1'b0, 32'h5B, 1'b0);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 24; it++) begin
            int waits;
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
                    applyStimulus(r, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    req_valid[r] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                int r0;
                r0 = $urandom_range(0, NREQ - 1);
                applyStimulus(r0, 1'($urandom_range(0, 1)), $urandom, $urandom);
                req_valid[r0] = 1'b1;
            end
            waits = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : $urandom_range(0, 3);
            runTransfer(waits, 1'($urandom_range(0, 3) == 0), $urandom, 1'b0);
        end
        req_valid = '0;
        repeat (3) @(posedge PCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
